// File: rtl/dcache_pass_mo_pkg.sv
// dcache_pass_mo_pkg: shared cpu/AXI definitions for the uncached data pass-through queue.
package dcache_pass_mo_pkg;
  typedef logic [31:0] phys_t;
  typedef logic [7:0] uint8_t;
  localparam int ID_W = 4;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  typedef enum logic [1:0] {IDLE, RD_AR, RD_R, WR_AW_W} iss_st_t;
  function automatic logic [2:0] axi_size(input int nb);
    return 3'($clog2(nb));
  endfunction
endpackage

// File: rtl/dcache_pass_mo_fifo.sv
// pass_line_fifo: line storage with tail/head pointers, count, issue/head read ports and in-place tail-1 update.
module pass_line_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc,
  input  logic          mrg,
  input  logic          pop,
  input  logic [W-1:0]  wline,
  input  logic [W-1:0]  mline,
  input  logic [AW-1:0] iss_ptr,
  output logic [W-1:0]  iss_line,
  output logic [W-1:0]  head_line,
  output logic [W-1:0]  tail_line,
  output logic          full
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] tail, head;
  logic [AW:0] count;
  always_ff @(posedge clk) begin
    if (alloc) mem[tail] <= wline;
    if (mrg) mem[tail - 1'b1] <= mline;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail <= '0;
      head <= '0;
      count <= '0;
    end else begin
      if (alloc) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + (AW+1)'(alloc) - (AW+1)'(pop);
    end
  end
  assign full = count == (AW+1)'(DEPTH);
  assign iss_line = mem[iss_ptr];
  assign head_line = mem[head];
  assign tail_line = mem[tail - 1'b1];
endmodule

// File: rtl/dcache_pass_mo.sv
// dcache_pass_mo: in-order uncached load/store queue with posted AXI3 writes.
// Store merging into the youngest unissued entry is enabled by DCACHE_PASS_MO_WMERGE_EN.
module dcache_pass_mo import dcache_pass_mo_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ARID = 2,
  parameter int AWID = 2,
  parameter int DATA_DEPTH = 8,
  parameter int WR_OUTSTANDING = 4,
  localparam int NB = DATA_WIDTH/8,
  localparam int OB = $clog2(NB),
  localparam int LABEL_WIDTH = 32 - OB,
  localparam int LW = 1 + NB + LABEL_WIDTH + DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LW-1:0]         pline,
  input  logic                  push,
  output logic                  full,
  output logic [LW-1:0]         rline,
  output logic                  rline_vld,
  output logic [ID_W-1:0]       ar_id,
  output logic [31:0]           ar_addr,
  output logic [3:0]            ar_len,
  output logic [2:0]            ar_size,
  output logic [1:0]            ar_burst,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic                  r_valid,
  output logic                  r_ready,
  output logic [ID_W-1:0]       aw_id,
  output logic [31:0]           aw_addr,
  output logic [3:0]            aw_len,
  output logic [2:0]            aw_size,
  output logic [1:0]            aw_burst,
  output logic                  aw_valid,
  input  logic                  aw_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [NB-1:0]         w_strb,
  output logic                  w_last,
  output logic                  w_valid,
  input  logic                  w_ready,
  input  logic                  b_valid,
  output logic                  b_ready
);
  localparam int AW = $clog2(DATA_DEPTH);
`ifdef DCACHE_PASS_MO_WMERGE_EN
  localparam bit WMERGE = 1'b1;
`else
  localparam bit WMERGE = 1'b0;
`endif
  typedef struct packed {
    logic                   ls;
    logic [NB-1:0]          be;
    logic [LABEL_WIDTH-1:0] label;
    logic [DATA_WIDTH-1:0]  data;
  } line_t;
  line_t pl, iss, hd, tl, mline;
  iss_st_t st, st_nx;
  logic aw_done, w_done, aw_hs, w_hs, wr_fin, r_hs, b_hs, retire, alloc, mrg;
  logic [AW-1:0] iss_ptr;
  logic [AW:0] unissued, wr_cnt;
  assign pl = pline;
  pass_line_fifo #(.W(LW), .DEPTH(DATA_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .alloc(alloc), .mrg(mrg), .pop(retire),
    .wline(pline), .mline(mline), .iss_ptr(iss_ptr),
    .iss_line(iss), .head_line(hd), .tail_line(tl), .full(full)
  );
  // Merge only while W for that entry has not yet been accepted by the bus.
  assign mrg = WMERGE && push && !pl.ls && unissued != '0 && !tl.ls && tl.label == pl.label &&
               !(st == WR_AW_W && (w_done || w_hs) && unissued == (AW+1)'(1));
  assign alloc = push && !full && !mrg;
  always_comb begin
    mline = tl;
    mline.be = tl.be | pl.be;
    for (int i = 0; i < NB; i++) mline.data[8*i +: 8] = pl.be[i] ? pl.data[8*i +: 8] : tl.data[8*i +: 8];
  end
  assign aw_hs = aw_valid && aw_ready;
  assign w_hs = w_valid && w_ready;
  assign wr_fin = st == WR_AW_W && (aw_done || aw_hs) && (w_done || w_hs);
  assign r_hs = st == RD_R && r_valid;
  // B always belongs to head; a stray B with nothing outstanding is ignored.
  assign b_hs = b_valid && wr_cnt != '0;
  assign retire = r_hs || b_hs;
  always_comb begin
    st_nx = st;
    if (st == IDLE && unissued != '0)
      st_nx = iss.ls ? (wr_cnt == '0 ? RD_AR : IDLE) : (wr_cnt < (AW+1)'(WR_OUTSTANDING) ? WR_AW_W : IDLE);
    if (st == RD_AR && ar_ready) st_nx = RD_R;
    if (r_hs || wr_fin) st_nx = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      iss_ptr <= '0;
      unissued <= '0;
      wr_cnt <= '0;
      rline <= '0;
      rline_vld <= 1'b0;
    end else begin
      st <= st_nx;
      aw_done <= st == WR_AW_W && !wr_fin && (aw_done || aw_hs);
      w_done <= st == WR_AW_W && !wr_fin && (w_done || w_hs);
      if (wr_fin || r_hs) iss_ptr <= iss_ptr + 1'b1;
      unissued <= unissued + (AW+1)'(alloc) - (AW+1)'(wr_fin || r_hs);
      wr_cnt <= wr_cnt + (AW+1)'(wr_fin) - (AW+1)'(b_hs);
      rline_vld <= retire;
      if (retire) rline <= r_hs ? {hd.ls, hd.be, hd.label, r_data} : hd;
    end
  end
  assign ar_id = ID_W'(ARID);
  assign ar_addr = 32'(iss.label) << OB;
  assign ar_len = '0;
  assign ar_size = axi_size(NB);
  assign ar_burst = AXI_BURST_INCR;
  assign ar_valid = st == RD_AR;
  assign r_ready = 1'b1;
  assign aw_id = ID_W'(AWID);
  assign aw_addr = 32'(iss.label) << OB;
  assign aw_len = '0;
  assign aw_size = axi_size(NB);
  assign aw_burst = AXI_BURST_INCR;
  assign aw_valid = st == WR_AW_W && !aw_done;
  assign w_data = iss.data;
  assign w_strb = iss.be;
  assign w_last = 1'b1;
  assign w_valid = st == WR_AW_W && !w_done;
  assign b_ready = 1'b1;
endmodule

// File: doc/dcache_pass_mo.md
# dcache_pass_mo

Uncached data-side pass-through queue with multiple outstanding writes: accepts load/store lines from the data cache's uncached path, issues them in order as single-beat AXI3 transactions, and returns every line in push order once its response arrives. It is the successor to the single-transaction pass queue. Stores are posted up to a programmable outstanding limit. Loads are held until all earlier writes have returned B, which preserves MMIO ordering. It sits between the dcache uncached port and the AXI3 read/write crossbar ports.

## Interface
- DATA_WIDTH, 32: data bus width; bytes per line NB = DATA_WIDTH/8.
- ARID, 2: constant ARID value.
- AWID, 2: constant AWID value.
- DATA_DEPTH, 8: queue entries; power of two, ≥2.
- WR_OUTSTANDING, 4: max issued stores without B; 1..DATA_DEPTH.
- Derived: LABEL_WIDTH = 32 − log2(NB). line_t = {ls_type(1, 0 = store, 1 = load), be[NB], label[LABEL_WIDTH], data[DATA_WIDTH]}.
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- pline  in  line_t  line to enqueue.
- push  in  1  enqueue strobe; ignored while full.
- full  out  1  queue holds DATA_DEPTH entries.
- rline  out  line_t  retired line; loads carry read data in the data field.
- rline_vld  out  1  single-cycle retire strobe.
- axi3_rd_if  master  BUS_WIDTH id  AR/R channels.
- axi3_wr_if  master  BUS_WIDTH id  AW/W/B channels.

## Operation
- Three pointers: tail (push), issue, head (retire). A count register drives full.
- Issue FSM states:
  - IDLE: examine the entry at issue.
  - RD_AR: ARVALID held until ARREADY, then move to RD_R.
  - RD_R: wait for RVALID.
  - WR_AW_W: AWVALID and WVALID raised together; each drops on its own handshake; leave when both are done.
- IDLE → RD_AR when the entry is a load and wr_cnt == 0.
- IDLE → WR_AW_W when the entry is a store and wr_cnt < WR_OUTSTANDING.
- A store advances the issue pointer on AW+W completion and increments wr_cnt.
- A load advances the issue pointer in RD_R on the R beat.
- Every BVALID decrements wr_cnt.
- AXI fields:
  - len = 0, size = log2(NB), burst = INCR, addr = {label, log2(NB) zeros}.
  - WSTRB = be, WLAST = 1.
  - BREADY = 1 and RREADY = 1 at all times.
- Retire, strictly in order at head:
  - A store retires on its B handshake.
  - A load retires on its R handshake; rline.data = RDATA and the other fields are unchanged.
  - The same AWID guarantees in-order B, so B always belongs to the oldest issued store, which is head whenever head is a store.

## Timing
- Push at edge N → entry visible at N+1; earliest ARVALID/AWVALID at N+1.
- Handshake at edge M → rline_vld high during the cycle after M, for one cycle.
- full reflects count only. A push while full is dropped even if a retire happens in the same cycle. Push and retire in the same non-full cycle leave count unchanged.
- Pointers wrap modulo DATA_DEPTH. Count saturates at DATA_DEPTH and at 0.
- A B and an R arriving in the same cycle cannot both target head. Only the head-matching handshake retires; the other is counted or held.
- Reset values: full = 0, rline_vld = 0, rline = 0, all VALIDs = 0, wr_cnt = 0, FSM = IDLE.
- Reset mid-operation drops all entries and abandons in-flight transactions. Responses arriving after reset are ignored.

## Configuration
- DCACHE_PASS_MO_WMERGE_EN defined:
  - A pushed store merges into the tail-most entry when that entry is a store, not yet issued, and has an equal label.
  - Merge result: be = old | new; bytes with new be set take the new data.
  - No new entry is allocated and no extra rline is produced.
  - A merge is allowed while full.
- Macro undefined: every push allocates an entry.

## Structure
- Shared package (the cpu defs): phys_t, uint8_t, the line_t/be_t/label_t typedef pattern, and AXI size/burst constants.
- One sub-module, pass_line_fifo: storage plus tail/head pointers and count.
  - It exposes read ports at issue and head, and write-in-place at tail−1 for merging.
  - The issue FSM and retire logic stay in the top.

## Test plan
- Single load, label 0x0000_0010, with mem word 0x1234_5678 → ARADDR 0x40, one R beat, rline {1,f,0x10,0x12345678}; rline_vld one cycle after R.
- Four stores pushed back-to-back with WR_OUTSTANDING = 4 and B delayed 10 cycles → four AW/W issued before the first B; four in-order rline_vld follow the B responses.
- A store to 0x40 followed by a load from 0x40 → ARVALID stays low until the B arrives; the load returns the stored data.
- Eight pushes with ARREADY/AWREADY held low → full = 1 after the 8th; a 9th push is dropped; releasing READY drains all 8 in order.
- With the macro defined: store be = 0011, data 0x0000_AABB, then store be = 1100, data 0xCCDD_0000, same label, while AWREADY = 0 → one AW, WSTRB 1111, WDATA 0xCCDD_AABB, one rline. With the macro undefined → two writes and two rlines.
- rst asserted during RD_R → ARVALID/full/rline_vld = 0 immediately; a late RVALID produces no rline_vld.
